// File: rtl/ha_serial_adder.sv
// ha_serial_adder: bit-serial adder built from two chained half-adders plus a
// carry flop. Operands are captured on start, summed LSB-first one bit per
// enabled clock, and the registered result is presented with a done pulse.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; sum/cout hold the last result
//   S_SHIFT | one result bit per enabled cycle, WIDTH cycles in total
//   S_DONE  | one enabled cycle; sum/cout freshly valid, done asserted
module ha_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic w_ha1_s;
    logic w_ha1_c;
    logic w_ha2_s;
    logic w_ha2_c;
    logic w_bit_c;
    logic w_last;

    // First half-adder combines the operand LSBs, the second folds in the
    // running carry; at most one of the two can generate a carry.
    assign w_ha1_s = r_op_a[0] ^ r_op_b[0];
    assign w_ha1_c = r_op_a[0] & r_op_b[0];
    assign w_ha2_s = w_ha1_s ^ r_carry;
    assign w_ha2_c = w_ha1_s & r_carry;
    assign w_bit_c = w_ha1_c | w_ha2_c;
    assign w_last  = (r_cnt == LAST_BIT);

    // Next-state decode; start is only honoured from idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; ena low freezes everything, reset overrides ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand capture, serial shift/add and result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_acc   <= {w_ha2_s, r_acc[WIDTH-1:1]};
                    r_op_a  <= {1'b0, r_op_a[WIDTH-1:1]};
                    r_op_b  <= {1'b0, r_op_b[WIDTH-1:1]};
                    r_carry <= w_bit_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum  <= {w_ha2_s, r_acc[WIDTH-1:1]};
                        r_cout <= w_bit_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_ha_serial_adder.sv
// tb_ha_serial_adder: directed and randomized additions checked against an
// arithmetic reference (a+b modulo 2^W, carry = bit W) and a timeline model
// that counts enabled edges since the accepted start.
module tb_ha_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_total;
    int n_bad;

    logic [W-1:0] exp_sum;
    logic         exp_cout;

    ha_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs(input string tag, input logic eb, input logic ed,
                               input logic [W-1:0] es, input logic ec);
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".sum"},  32'(sum),  32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
    endtask

    // One complete addition. stall_at = enabled edges after acceptance at
    // which ena drops for stall_len cycles; poke raises start with junk
    // operands while busy and in the done cycle.
    task automatic run_add(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                           input int stall_at, input int stall_len, input bit poke);
        logic [W:0]   full;
        logic [W-1:0] new_sum;
        logic         new_cout;
        int           n;
        int           stalls;
        int           done_cyc;
        int           done_cnt;
        int           want_lat;
        full     = {1'b0, op_a} + {1'b0, op_b};
        new_sum  = full[W-1:0];
        new_cout = full[W];

        rst = 1'b0; ena = 1'b1; start = 1'b1; a = op_a; b = op_b;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        n = 0; stalls = 0; done_cyc = -1; done_cnt = 0;
        chk_outputs({tag, ".acc"}, 1'b1, 1'b0, exp_sum, exp_cout);

        for (int cyc = 1; cyc <= W + 1 + stall_len; cyc++) begin
            ena = !(n == stall_at && stalls < stall_len);
            if (poke && (n == 2 || n == W)) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            if (ena) n++;
            else     stalls++;
            if (n >= W) begin
                exp_sum  = new_sum;
                exp_cout = new_cout;
            end
            chk_outputs(tag, (n < W), (n == W), exp_sum, exp_cout);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        start = 1'b0; ena = 1'b1;
        want_lat = W + ((stall_at < W) ? stall_len : 0);
        chk({tag, ".latency"}, 32'(done_cyc), 32'(want_lat));
        chk({tag, ".done_cycles"}, 32'(done_cnt), 32'((stall_at == W) ? stall_len + 1 : 1));
    endtask

    task automatic idle_cycles(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            ena = 1'($urandom); start = 1'b0;
            a = W'($urandom); b = W'($urandom);
            tick();
            chk_outputs(tag, 1'b0, 1'b0, exp_sum, exp_cout);
        end
        ena = 1'b1;
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        rst = 1'b1; ena = 1'b1; start = 1'b1; a = '1; b = '1;
        exp_sum = '0; exp_cout = 1'b0;

        // Reset dominates start.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_outputs("reset", 1'b0, 1'b0, 8'h00, 1'b0);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        chk_outputs("reset_rel", 1'b0, 1'b0, 8'h00, 1'b0);

        run_add("basic", 8'h5A, 8'h33, 99, 0, 1'b0);
        chk("basic.value", 32'(sum), 32'h8D);
        idle_cycles("basic_hold", 3);

        run_add("ovf_ff01", 8'hFF, 8'h01, 99, 0, 1'b0);
        chk("ovf_ff01.value", 32'({cout, sum}), 32'h100);
        run_add("ovf_8080", 8'h80, 8'h80, 99, 0, 1'b0);
        chk("ovf_8080.value", 32'({cout, sum}), 32'h100);
        run_add("zero", 8'h00, 8'h00, 99, 0, 1'b0);
        chk("zero.value", 32'({cout, sum}), 32'h000);

        run_add("basic2", 8'h5A, 8'h33, 99, 0, 1'b0);
        run_add("ignored_start", 8'h01, 8'h02, 99, 0, 1'b1);
        chk("ignored_start.value", 32'(sum), 32'h03);
        idle_cycles("ignored_hold", 2);

        run_add("stall", 8'hC8, 8'h64, 4, 3, 1'b0);
        chk("stall.value", 32'({cout, sum}), 32'h12C);

        run_add("stall_done", 8'h37, 8'h91, W, 2, 1'b0);

        // Abort mid-operation with reset.
        ena = 1'b1; start = 1'b1; a = 8'h0F; b = 8'h0F;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("midop.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        chk_outputs("midop_rst", 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            chk_outputs("midop_quiet", 1'b0, 1'b0, 8'h00, 1'b0);
        end
        run_add("after_rst", 8'h10, 8'h20, 99, 0, 1'b0);
        chk("after_rst.value", 32'({cout, sum}), 32'h030);

        // Randomized operands, stall placement and start pokes.
        for (int t = 0; t < 30; t++) begin
            run_add("rand", W'($urandom), W'($urandom),
                    int'($urandom_range(0, W + 2)), int'($urandom_range(0, 3)),
                    1'($urandom));
            idle_cycles("rand_hold", int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
